// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit for the five-stage pipeline.
// Holds a private destination-tag pipe (entry 0 = EX, 1 = MEM, 2 = WB, ...)
// that shifts every clock. It resolves rs1/rs2 of the ID instruction against
// the youngest matching producer and raises a one-cycle stall when that
// producer is a load still sitting in EX.
module fwd_hazard_unit #(
   parameter int XLEN  = 32,
   parameter int RA_W  = 5,
   parameter int DEPTH = 3,
   parameter int CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    id_valid,
   input  logic [RA_W-1:0]         id_rs1,
   input  logic [RA_W-1:0]         id_rs2,
   input  logic                    id_use_rs1,
   input  logic                    id_use_rs2,
   input  logic [RA_W-1:0]         id_rd,
   input  logic                    id_we,
   input  logic                    id_is_load,
   input  logic [XLEN-1:0]         id_rd1,
   input  logic [XLEN-1:0]         id_rd2,
   input  logic                    flush,
   input  logic [DEPTH*XLEN-1:0]   stage_data,
   output logic [XLEN-1:0]         op1,
   output logic [XLEN-1:0]         op2,
   output logic [2:0]              fwd_sel1,
   output logic [2:0]              fwd_sel2,
   output logic                    stall,
   output logic [CNT_W-1:0]        stall_cnt
);

   localparam int NSRC = 2;

   // Tag pipe, one bit/field per tracked stage.
   logic [DEPTH-1:0]           vld_pipe;
   logic [DEPTH-1:0]           we_pipe;
   logic [DEPTH-1:0]           ld_pipe;
   logic [DEPTH-1:0][RA_W-1:0] rd_pipe;

   // Per-source views so both operands share one resolver body.
   logic [RA_W-1:0] src      [NSRC];
   logic            src_use  [NSRC];
   logic [XLEN-1:0] rf_data  [NSRC];
   logic [XLEN-1:0] op       [NSRC];
   logic [2:0]      sel      [NSRC];
   logic            hazard   [NSRC];

   assign src[0]     = id_rs1;
   assign src[1]     = id_rs2;
   assign src_use[0] = id_use_rs1;
   assign src_use[1] = id_use_rs2;
   assign rf_data[0] = id_rd1;
   assign rf_data[1] = id_rd2;

   for (genvar s = 0; s < NSRC; s++) begin : g_src
      logic [XLEN-1:0] op_s;
      logic [2:0]      sel_s;
      logic            haz_s;
      logic            found;

      // Scan from EX outward; the first hit is the youngest producer and wins.
      // x0 never matches because rd == 0 producers are ignored.
      always_comb begin
         op_s  = rf_data[s];
         sel_s = '0;
         haz_s = 1'b0;
         found = 1'b0;
         for (int k = 0; k < DEPTH; k++) begin
            if (!found && src_use[s] && vld_pipe[k] && we_pipe[k] &&
                rd_pipe[k] != '0 && rd_pipe[k] == src[s]) begin
               found = 1'b1;
               op_s  = stage_data[k*XLEN +: XLEN];
               sel_s = 3'(k + 1);
               haz_s = (k == 0) && ld_pipe[k];
            end
         end
      end

      assign op[s]     = op_s;
      assign sel[s]    = sel_s;
      assign hazard[s] = haz_s;
   end

   assign op1      = op[0];
   assign op2      = op[1];
   assign fwd_sel1 = sel[0];
   assign fwd_sel2 = sel[1];

   // Load data is not available in EX, so only an entry-0 load stalls;
   // a flushed ID instruction never needs its operands.
   assign stall = (hazard[0] | hazard[1]) & id_valid & ~flush;

   // Shift the tag pipe every cycle; stalls and flushes inject a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         we_pipe  <= '0;
         ld_pipe  <= '0;
         rd_pipe  <= '0;
      end else begin
         vld_pipe[0] <= id_valid & ~flush & ~stall;
         we_pipe[0]  <= id_we;
         ld_pipe[0]  <= id_is_load;
         rd_pipe[0]  <= id_rd;
         for (int k = 1; k < DEPTH; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            we_pipe[k]  <= we_pipe[k-1];
            ld_pipe[k]  <= ld_pipe[k-1];
            rd_pipe[k]  <= rd_pipe[k-1];
         end
      end
   end

   // Saturating count of stall cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (stall && stall_cnt != '1)
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed vector table for the scripted corner
// cases, then randomized traffic checked against a history-queue model.
module tb_fwd_hazard_unit;

   localparam int XLEN = 32, RA_W = 5, DEP = 3, CNT_W = 4;
   localparam logic [31:0] R1 = 32'h1111_1111, R2 = 32'h2222_2222;
   localparam logic [31:0] D0 = 32'h0000_1234, D1 = 32'h0000_0B0B, D2 = 32'h0000_0C0C;

   logic clk = 1'b0, rst_n = 1'b1;
   logic id_valid, id_use_rs1, id_use_rs2, id_we, id_is_load, flush;
   logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
   logic [XLEN-1:0] id_rd1, id_rd2, op1, op2;
   logic [DEP*XLEN-1:0] stage_data;
   logic [2:0] fwd_sel1, fwd_sel2;
   logic stall;
   logic [CNT_W-1:0] stall_cnt;

   int n_chk = 0, n_fail = 0;

   fwd_hazard_unit #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEP), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .flush(flush), .stage_data(stage_data),
      .op1(op1), .op2(op2), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
      .stall(stall), .stall_cnt(stall_cnt));

   always #5 clk = ~clk;

   typedef struct {
      logic v; logic [4:0] rs1, rs2; logic u1, u2; logic [4:0] rd; logic we, ld, fl;
      logic [31:0] sd0, sd1, sd2;
      logic [31:0] e_op1, e_op2; logic [2:0] e_s1, e_s2; logic e_st; logic [3:0] e_cnt;
   } vec_t;

   // What each tracked stage holds; hist[0] is the instruction now in EX.
   typedef struct { logic v; logic [4:0] rd; logic we, ld; } tag_t;
   tag_t hist[$];
   int   mcnt;
   vec_t tv[19];
   vec_t nullv;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_model();
      hist.delete();
      for (int k = 0; k < DEP; k++) hist.push_back('{v: 1'b0, rd: 5'd0, we: 1'b0, ld: 1'b0});
      mcnt = 0;
   endtask

   // Youngest in-flight writer of a used, non-zero source supplies the value.
   task automatic model_eval(input logic [4:0] s, input logic u, input logic [31:0] rf,
                             output logic [31:0] o, output logic [2:0] sl, output logic hz);
      o = rf; sl = 3'd0; hz = 1'b0;
      if (u && s != 5'd0) begin
         for (int k = 0; k < DEP; k++) begin
            if (hist[k].v && hist[k].we && hist[k].rd == s) begin
               o  = stage_data[k*XLEN +: XLEN];
               sl = 3'(k + 1);
               hz = (k == 0) && hist[k].ld;
               break;
            end
         end
      end
   endtask

   // Inputs are already driven (posedge+1); check at posedge+2, then clock.
   task automatic run_cycle(input bit use_tab, input vec_t t, input string nm);
      logic [31:0] mo1, mo2; logic [2:0] ms1, ms2; logic mh1, mh2, mst;
      #1;
      model_eval(id_rs1, id_use_rs1, id_rd1, mo1, ms1, mh1);
      model_eval(id_rs2, id_use_rs2, id_rd2, mo2, ms2, mh2);
      mst = (mh1 | mh2) & id_valid & ~flush;
      if (use_tab) begin
         chk({nm, ".stall"}, 32'(stall), 32'(t.e_st));
         chk({nm, ".cnt"}, 32'(stall_cnt), 32'(t.e_cnt));
         if (!t.e_st) begin
            chk({nm, ".sel1"}, 32'(fwd_sel1), 32'(t.e_s1));
            chk({nm, ".sel2"}, 32'(fwd_sel2), 32'(t.e_s2));
            chk({nm, ".op1"}, op1, t.e_op1);
            chk({nm, ".op2"}, op2, t.e_op2);
         end
      end else begin
         chk({nm, ".stall"}, 32'(stall), 32'(mst));
         chk({nm, ".cnt"}, 32'(stall_cnt), 32'(mcnt));
         if (!mst) begin
            chk({nm, ".sel1"}, 32'(fwd_sel1), 32'(ms1));
            chk({nm, ".sel2"}, 32'(fwd_sel2), 32'(ms2));
            chk({nm, ".op1"}, op1, mo1);
            chk({nm, ".op2"}, op2, mo2);
         end
      end
      @(posedge clk);
      hist.push_front('{v: id_valid & ~flush & ~mst, rd: id_rd, we: id_we, ld: id_is_load});
      void'(hist.pop_back());
      if (mst && mcnt != 15) mcnt++;
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rs1, rs2, input logic u1, u2,
                        input logic [4:0] rd, input logic we, ld, fl);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
      id_rd = rd; id_we = we; id_is_load = ld; flush = fl;
   endtask

   initial begin
      // v rs1 rs2 u1 u2 rd we ld fl | sd0 sd1 sd2 | op1 op2 s1 s2 st cnt
      tv[0]  = '{1, 1, 2,1,1, 5,1,0,0, D0,D1,D2, R1,R2,0,0,0,0};  // add x5
      tv[1]  = '{1, 5, 1,1,1, 6,1,0,0, D0,D1,D2, D0,R2,1,0,0,0};  // sub x6,x5,x1
      tv[2]  = '{1, 0, 0,0,0, 7,1,0,0, D0,D1,D2, R1,R2,0,0,0,0};  // x7 writer
      tv[3]  = '{1, 0, 0,0,0, 7,1,0,0, D0,D1,D2, R1,R2,0,0,0,0};
      tv[4]  = '{1, 0, 0,0,0, 7,1,0,0, D0,D1,D2, R1,R2,0,0,0,0};
      tv[5]  = '{1, 0, 7,1,1, 0,0,0,0, 32'hC,32'hB,32'hA, R1,32'hC,0,1,0,0}; // sw x7
      tv[6]  = '{1, 1, 0,1,0, 8,1,1,0, D0,D1,D2, R1,R2,0,0,0,0};  // lw x8
      tv[7]  = '{1, 8, 8,1,1, 9,1,0,0, D0,D1,D2, 0,0,0,0,1,0};    // add x9,x8,x8 stalls
      tv[8]  = '{1, 8, 8,1,1, 9,1,0,0, D0,32'h8888,D2, 32'h8888,32'h8888,2,2,0,1};
      tv[9]  = '{1, 1, 0,1,0, 0,1,0,0, D0,D1,D2, R1,R2,0,0,0,1};  // writer to x0
      tv[10] = '{1, 0, 0,1,1,10,1,1,0, D0,D1,D2, R1,R2,0,0,0,1};  // reads x0; lw x10
      tv[11] = '{1, 1,10,1,0,11,1,0,0, D0,D1,D2, R1,R2,0,0,0,1};  // rs2 unused
      tv[12] = '{1, 1, 0,1,0,12,1,1,0, D0,D1,D2, R1,R2,0,0,0,1};  // lw x12
      tv[13] = '{1,12, 0,1,0,14,1,0,1, 32'h5151,D1,D2, 32'h5151,R2,1,0,0,1}; // flush wins
      tv[14] = '{1,12, 0,1,0,14,1,0,0, D0,32'h6161,D2, 32'h6161,R2,2,0,0,1}; // bubble in EX
      tv[15] = '{1, 1, 0,1,0,13,1,1,0, D0,D1,D2, R1,R2,0,0,0,1};  // lw x13
      tv[16] = '{1, 1, 0,1,0,13,1,1,0, D0,D1,D2, R1,R2,0,0,0,1};  // lw x13 again
      tv[17] = '{1,13, 0,1,0,15,1,0,0, D0,D1,D2, 0,0,0,0,1,1};    // youngest is load in EX
      tv[18] = '{1,13, 0,1,0,15,1,0,0, D0,32'h7171,D2, 32'h7171,R2,2,0,0,2};
      nullv = tv[0];

      // Reset state, with live ID traffic present.
      drive(1, 5'd1, 5'd2, 1, 1, 5'd1, 1, 1, 0);
      id_rd1 = R1; id_rd2 = R2; stage_data = {D2, D1, D0};
      #1 rst_n = 1'b0;
      #2;
      chk("rst.stall", 32'(stall), 32'd0);
      chk("rst.sel1", 32'(fwd_sel1), 32'd0);
      chk("rst.sel2", 32'(fwd_sel2), 32'd0);
      chk("rst.op1", op1, R1);
      chk("rst.op2", op2, R2);
      chk("rst.cnt", 32'(stall_cnt), 32'd0);
      id_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      clear_model();

      // Directed vectors.
      for (int i = 0; i < 19; i++) begin
         drive(tv[i].v, tv[i].rs1, tv[i].rs2, tv[i].u1, tv[i].u2, tv[i].rd, tv[i].we, tv[i].ld, tv[i].fl);
         id_rd1 = R1; id_rd2 = R2;
         stage_data = {tv[i].sd2, tv[i].sd1, tv[i].sd0};
         run_cycle(1'b1, tv[i], $sformatf("vec%0d", i));
      end

      // Randomized traffic over a small register range to force frequent matches.
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 9) < 8), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
               1'($urandom), 1'($urandom_range(0, 9) == 0));
         id_rd1 = $urandom; id_rd2 = $urandom;
         stage_data = {$urandom, $urandom, $urandom};
         run_cycle(1'b0, nullv, $sformatf("rnd%0d", i));
      end

      // Self-dependent load stream: stalls every other cycle, saturating the counter.
      for (int i = 0; i < 44; i++) begin
         drive(1, 5'd20, 5'd0, 1, 0, 5'd20, 1, 1, 0);
         stage_data = {$urandom, $urandom, $urandom};
         run_cycle(1'b0, nullv, $sformatf("sat%0d", i));
      end
      chk("sat.cnt", 32'(stall_cnt), 32'hF);

      // Reset in the middle of a load-use stall.
      drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
      run_cycle(1'b0, nullv, "pre0");
      drive(1, 5'd1, 5'd0, 1, 0, 5'd21, 1, 1, 0);
      run_cycle(1'b0, nullv, "pre1");
      drive(1, 5'd21, 5'd21, 1, 1, 5'd22, 1, 0, 0);
      id_rd1 = R1; id_rd2 = R2;
      #1;
      chk("mid.stall_before", 32'(stall), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid.stall", 32'(stall), 32'd0);
      chk("mid.cnt", 32'(stall_cnt), 32'd0);
      chk("mid.sel1", 32'(fwd_sel1), 32'd0);
      chk("mid.sel2", 32'(fwd_sel2), 32'd0);
      chk("mid.op1", op1, R1);
      chk("mid.op2", op2, R2);
      id_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      clear_model();

      // Traffic after reset release must start from a clean pipe.
      for (int i = 0; i < 20; i++) begin
         drive(1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1, 1,
               5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 0);
         id_rd1 = $urandom; id_rd2 = $urandom;
         stage_data = {$urandom, $urandom, $urandom};
         run_cycle(1'b0, nullv, $sformatf("post%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand-forwarding and load-use hazard unit for the five-stage pipeline. It resolves both source operands (rs1, rs2) of the instruction in ID against a configurable number of in-flight destination stages, and raises a one-cycle stall for load-use hazards. It owns its own destination-tag pipeline, kept in step with EX/MEM/WB, and a saturating stall performance counter. It sits beside the ID/EX register and feeds the ALU operand muxes and the DRAM store-data path.

## Interface
- XLEN, 32, datapath width
- RA_W, 5, register address width
- DEPTH, 3, tracked in-flight stages (entry 0 = EX, 1 = MEM, 2 = WB, …); legal range 1..4
- CNT_W, 32, stall counter width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  RA_W  ID source addresses
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
- id_rd  in  RA_W  ID destination address
- id_we  in  1  ID instruction writes the register file
- id_is_load  in  1  ID instruction is a load
- id_rd1, id_rd2  in  XLEN  register-file read data
- flush  in  1  discard the ID instruction this cycle (taken branch/jump)
- stage_data  in  DEPTH*XLEN  result currently held by stage k at [k*XLEN +: XLEN]
- op1, op2  out  XLEN  resolved operands
- fwd_sel1, fwd_sel2  out  3  0 = register file; k+1 = forwarded from entry k
- stall  out  1  freeze PC and IF/ID; bubble into EX
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- **Tag pipe.** DEPTH entries, each holding {valid, rd, we, is_load}. They shift every clock; there is no pipe-hold input.
- **Entry 0 next value.**
  - Bubble (valid=0) when any of: `!id_valid`, `flush`, or `stall`.
  - Otherwise {1, id_rd, id_we, id_is_load}.
- **Entry k (k ≥ 1) next value.** Entry k−1.
- **Match condition (entry k, source s).** All of:
  - entry k valid and we
  - rd ≠ 0 and rd == s
  - the matching id_use_rsX is set
- **Operand resolution.** Per source, pick the lowest-index matching entry (youngest wins). If none matches, or the source is x0, use id_rdX with fwd_sel = 0.
- **Load-use hazard.** A source matches entry 0 and that entry has is_load=1.
  - Load data is not ready in EX, so stall = hazard & id_valid & !flush.
  - While stall is high, op1/op2 are don't-care.
- **Load data from entry ≥ 1.** Loads matching entry ≥ 1 forward normally. The datapath supplies load data on stage_data for MEM and later.
- **Stall counter.** stall_cnt increments on each clock where stall=1 and saturates at all-ones.
- **Combinational outputs.** op1, op2, fwd_sel1, fwd_sel2 and stall are combinational from the registered tags plus current inputs. stall never depends on stage_data.

## Timing
- **Reset (async assert, sync release).**
  - All entries invalid; stall_cnt = 0.
  - Outputs during reset: stall = 0, fwd_sel = 0, op1/op2 = id_rd1/id_rd2.
- **Tag latency.** An instruction in ID at cycle t appears in entry 0 at t+1 and in entry k at t+1+k.
- **Load-use stall length.** Exactly one cycle.
  - Cycle t+1: stall asserted; entry 0 = load.
  - Cycle t+2: the bubble is in entry 0 and the load is in entry 1; stall drops and the operand forwards from entry 1.
- **flush and hazard in the same cycle.** flush wins: stall = 0, bubble inserted, counter unchanged.
- **Back-to-back loads to the same rd.** The youngest match drives the decision: a stall is raised only if that match is in entry 0.
- **Same source in both fields.** When rs1 == rs2, both operands resolve identically; a single stall is raised.
- **DEPTH = 1.** Only EX forwarding exists. Older results must come from the register file, which writes before it reads.
- **Reset mid-stall.** The tag pipe clears immediately; stall falls asynchronously with rst_n low.

## Test plan
- **ALU chain.** `add x5` then `sub x6,x5,x1` next cycle, with stage_data[0] = 0x0000_1234 -> op1 = 0x1234, fwd_sel1 = 1, stall = 0.
- **Priority.** x7 written by the instructions in entries 2, 1 and 0 with data 0xA, 0xB, 0xC, then `sw x7` in ID -> op2 = 0xC, fwd_sel2 = 1.
- **Load-use.** `lw x8` then `add x9,x8,x8` -> stall = 1 for one cycle and stall_cnt goes 0 → 1. Next cycle: fwd_sel1 = fwd_sel2 = 2, op1 = op2 = stage_data[1].
- **x0 and unused sources.** Writer to x0 followed by a reader of x0 -> fwd_sel = 0, op = id_rd. A matching rs2 with id_use_rs2 = 0 -> no forward and no stall.
- **Flush versus hazard.** Load in entry 0, a dependent instruction in ID, and flush = 1 -> stall = 0. Next cycle entry 0 is invalid and the counter is unchanged.
- **Reset and saturation.** With CNT_W = 4, force 20 stalls -> stall_cnt holds 0xF. Pulse rst_n low mid-stall -> stall = 0 immediately, stall_cnt = 0, all fwd_sel = 0.
